systolic_ctrl: RTL and testbench

Sequencer for the DIM×DIM output-stationary systolic PE array. On `start` it runs three phases:
- **Feed:** generates skewed lane enables so row i of A and column j of B enter the array with i/j cycles of skew.
- **Flush:** lets the last products reach the far PEs.
- **Drain:** drives `output_sign` so accumulated C values shift out of the bottom row, one row per beat, under `out_ready` back-pressure.

It sits between the operand buffers, the array, and the result writer.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/systolic_lane_mask.sv | 22 ++
 rtl/systolic_ctrl.sv | 130 +++++++++++++
 tb/tb_systolic_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array sequencer.
// Holds the state encoding and the per-lane feed window test.
package systolic_pkg;

   localparam int DIM_DEF  = 4;
   localparam int KMAX_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Lane carries data while t is inside [lane, lane+k).
   function automatic logic lane_on(
      input int t,
      input int k,
      input int lane
   );
      return (t >= lane) && (t < lane + k);
   endfunction

endpackage

// File: rtl/systolic_lane_mask.sv
// Skewed lane-enable mask from the feed counter and inner dimension.
// Also used by the operand-buffer address generator.
module systolic_lane_mask
   import systolic_pkg::*;
#(
   parameter int DIM = DIM_DEF,
   parameter int CW  = 5,
   parameter int KW  = 5
) (
   input  logic [CW-1:0]  feed_t,
   input  logic [KW-1:0]  k,
   output logic [DIM-1:0] lane_en
);

   always_comb begin
      lane_en = '0;
      for (int i = 0; i < DIM; i++) begin
         lane_en[i] = lane_on(32'(feed_t), 32'(k), i);
      end
   end

endmodule

// File: rtl/systolic_ctrl.sv
// Feed/flush/drain sequencer for the DIM x DIM output-stationary array.
// Only output_sign and lane_en are combinational; the rest are flops.
module systolic_ctrl
   import systolic_pkg::*;
#(
   parameter int DIM  = DIM_DEF,
   parameter int KMAX = KMAX_DEF,
   parameter int CW   = $clog2(KMAX + 2 * DIM)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(KMAX+1)-1:0]  k_len,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done,
   output logic [CW-1:0]              feed_t,
   output logic [DIM-1:0]             lane_en,
   output logic                       output_sign,
   output logic                       out_valid,
   output logic [$clog2(DIM)-1:0]     out_row
);

   localparam int KW = $clog2(KMAX + 1);
   localparam int RW = $clog2(DIM);
   localparam int DW = $clog2(DIM + 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   feed_t_q, feed_t_d;
   logic [KW-1:0]   k_q, k_d;
   logic [DW-1:0]   d_q, d_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            out_valid_q, out_valid_d;
   logic [RW-1:0]   out_row_q, out_row_d;
   logic [CW:0]     feed_last;
   logic [DIM-1:0]  mask;

   systolic_lane_mask #(
      .DIM (DIM),
      .CW  (CW),
      .KW  (KW)
   ) u_mask (
      .feed_t  (feed_t_q),
      .k       (k_q),
      .lane_en (mask)
   );

   // Last feed index is K+2*DIM-3; one spare bit keeps the sum exact.
   assign feed_last = (CW+1)'(k_q) + (CW+1)'(2 * DIM - 3);

   always_comb begin
      state_d     = state_q;
      feed_t_d    = feed_t_q;
      k_d         = k_q;
      d_d         = d_q;
      output_sign = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_FEED;
               feed_t_d = '0;
               d_d      = '0;
               k_d      = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
            end
         end
         ST_FEED: begin
            feed_t_d = feed_t_q + 1'b1;
            if ({1'b0, feed_t_q} == feed_last) begin
               state_d  = ST_DRAIN;
               feed_t_d = '0;
               d_d      = '0;
            end
         end
         ST_DRAIN: begin
            output_sign = out_ready;
            if (out_ready) begin
               d_d = d_q + 1'b1;
               if (d_q == DW'(DIM - 1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d      = (state_d == ST_FEED) || (state_d == ST_DRAIN);
      done_d      = (state_d == ST_DONE);
      out_valid_d = (state_d == ST_DRAIN);
      out_row_d   = '0;
      if (state_d == ST_DRAIN) begin
         out_row_d = RW'(DIM - 1) - RW'(d_d);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         feed_t_q    <= '0;
         k_q         <= '0;
         d_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
      end else begin
         state_q     <= state_d;
         feed_t_q    <= feed_t_d;
         k_q         <= k_d;
         d_q         <= d_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
      end
   end

   assign lane_en   = (state_q == ST_FEED) ? mask : '0;
   assign busy      = busy_q;
   assign done      = done_q;
   assign feed_t    = feed_t_q;
   assign out_valid = out_valid_q;
   assign out_row   = out_row_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with a job-level reference model.
module tb_systolic_ctrl;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [4:0] k_len = '0;
   logic       out_ready = 1'b1;
   logic       busy, done, output_sign, out_valid;
   logic [4:0] feed_t;
   logic [3:0] lane_en;
   logic [1:0] out_row;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int t0 = 0;
   bit bp = 1'b0;

   logic [3:0] r_lane [0:127];
   logic       r_valid [0:127];
   logic [1:0] r_row [0:127];
   logic       r_sign [0:127];

   systolic_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .k_len       (k_len),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done),
      .feed_t      (feed_t),
      .lane_en     (lane_en),
      .output_sign (output_sign),
      .out_valid   (out_valid),
      .out_row     (out_row)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer stalls in job cycles 12 and 13 when back-pressure is on.
   always @(posedge clk) begin
      #2;
      out_ready = !(bp && ((cyc - t0) == 12 || (cyc - t0) == 13));
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   // Job-level model: m_t counts cycles since the accepted start.
   bit m_job = 0;
   bit m_done = 0;
   int m_t = 0;
   int m_K = 0;
   int m_beats = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_job = 0;
         m_done = 0;
         m_t = 0;
         m_beats = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (!m_job) begin
         if (start) begin
            m_job = 1;
            m_t = 1;
            m_K = (k_len > 16) ? 16 : int'(k_len);
            m_beats = 0;
         end
      end else if (m_t <= m_K + 2 * D - 2) begin
         m_t++;
      end else if (out_ready) begin
         m_beats++;
         if (m_beats == D) begin
            m_job = 0;
            m_done = 1;
         end
      end
   end

   always @(negedge clk) begin
      bit ef, ed;
      logic [3:0] el;
      ef = m_job && (m_t <= m_K + 2 * D - 2);
      ed = m_job && !ef;
      el = '0;
      for (int i = 0; i < D; i++)
         el[i] = ef && (m_t - 1 >= i) && (m_t - 1 < i + m_K);
      chk("busy", busy, m_job);
      chk("done", done, m_done);
      chk("out_valid", out_valid, ed);
      chk("output_sign", output_sign, ed && out_ready);
      chk("lane_en", lane_en, el);
      if (ef) chk("feed_t", feed_t, m_t - 1);
      if (ed) chk("out_row", out_row, D - 1 - m_beats);
   end

   task automatic go(input logic [4:0] k);
      @(posedge clk);
      #2;
      k_len = k;
      start = 1'b1;
      t0 = cyc;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic run(input logic [4:0] k, input int p1,
                      input int p2, output int dc);
      go(k);
      dc = -1;
      for (int n = 1; n < 100; n++) begin
         @(negedge clk);
         r_lane[n] = lane_en;
         r_valid[n] = out_valid;
         r_row[n] = out_row;
         r_sign[n] = output_sign;
         if (done) begin
            dc = n;
            break;
         end
         @(posedge clk);
         #2;
         start = (n + 1 == p1) || (n + 1 == p2);
      end
      start = 1'b0;
      chk("done_within_budget", dc >= 0, 1);
   endtask

   int dc;
   logic [3:0] nom_lane [0:9] = '{4'b0001, 4'b0011, 4'b0111,
      4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
   logic [3:0] k1_lane [0:6] = '{4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0000, 4'b0000, 4'b0000};

   initial begin
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_row", out_row, 0);
      chk("rst_lane", lane_en, 0);
      chk("rst_feed_t", feed_t, 0);
      @(posedge clk);
      #2 rst = 1'b0;

      // Nominal K=4
      run(5'd4, -1, -1, dc);
      chk("nom_done_cycle", dc, 15);
      for (int i = 0; i < 10; i++)
         chk($sformatf("nom_lane_c%0d", i + 1), r_lane[i + 1], nom_lane[i]);
      chk("nom_valid_c10", r_valid[10], 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("nom_valid_c%0d", 11 + i), r_valid[11 + i], 1);
         chk($sformatf("nom_row_c%0d", 11 + i), r_row[11 + i], 3 - i);
      end

      // Back-pressure in cycles 12..13
      bp = 1'b1;
      run(5'd4, -1, -1, dc);
      bp = 1'b0;
      chk("bp_done_cycle", dc, 17);
      chk("bp_sign_c12", r_sign[12], 0);
      chk("bp_sign_c13", r_sign[13], 0);
      chk("bp_row_c12", r_row[12], 2);
      chk("bp_row_c13", r_row[13], 2);
      chk("bp_sign_c14", r_sign[14], 1);
      chk("bp_row_c16", r_row[16], 0);

      // K=1
      run(5'd1, -1, -1, dc);
      chk("k1_done_cycle", dc, 12);
      for (int i = 0; i < 7; i++)
         chk($sformatf("k1_lane_c%0d", i + 1), r_lane[i + 1], k1_lane[i]);
      chk("k1_valid_c8", r_valid[8], 1);

      // K=0
      run(5'd0, -1, -1, dc);
      chk("k0_done_cycle", dc, 11);
      for (int i = 1; i <= 6; i++)
         chk($sformatf("k0_lane_c%0d", i), r_lane[i], 0);
      chk("k0_valid_c7", r_valid[7], 1);

      // Start pulses in FEED and DRAIN are ignored
      run(5'd4, 5, 12, dc);
      chk("ign_done_cycle", dc, 15);
      // Restart in the cycle right after done
      run(5'd4, -1, -1, dc);
      chk("b2b_done_cycle", dc, 15);

      // k_len above KMAX saturates to 16
      run(5'd20, -1, -1, dc);
      chk("sat_done_cycle", dc, 27);

      // Reset in FEED cycle 3
      go(5'd4);
      @(posedge clk);
      #2;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_lane", lane_en, 0);
      chk("arst_feed_t", feed_t, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_done", done, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      begin
         int seen;
         seen = 0;
         repeat (20) begin
            @(negedge clk);
            if (done) seen++;
         end
         chk("arst_no_done", seen, 0);
      end
      run(5'd4, -1, -1, dc);
      chk("arst_fresh_done", dc, 15);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
